fsub_pipe: RTL
==============

# fsub_pipe

Three-stage pipelined IEEE-754 single-precision subtractor computing c = a − b, with a valid/ready handshake on both sides. It follows the same special-case, flush-to-zero and rounding rules as the team's combinational adder, so the two units give identical results for a − b and a + (−b). It sits beside the adder in the FPU and is driven by the issue logic. Results return in order to the writeback arbiter.

## Interface
- `TAG_W`, default 4: width of the opaque tag carried alongside each operation.
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: `a`, `b` and `in_tag` are valid this cycle.
- `in_ready`, output, 1: the block accepts an operation this cycle.
- `a`, input, 32: minuend.
- `b`, input, 32: subtrahend.
- `in_tag`, input, `TAG_W`: tag returned unchanged with the result.
- `out_valid`, output, 1: `c` and `out_tag` hold a result.
- `out_ready`, input, 1: the consumer takes the result this cycle.
- `c`, output, 32: a − b.
- `out_tag`, output, `TAG_W`: tag of the operation in `c`.

## Operation
- **Negation:** b′ = {~b[31], b[30:0]}. The rest of the datapath is an adder on a and b′.
- **Special cases, in priority order:**
  - Any NaN input (exp = 0xff, mant ≠ 0) gives 0x7fffffff.
  - a = +inf and b′ = +inf, or a = −inf and b′ = −inf, is not NaN; the NaN case is a and b′ being opposite infinities, which gives 0x7fffffff.
  - One infinity present gives that signed infinity.
  - Both exp = 0 gives 0x00000000.
  - Only a has exp = 0: result is b′.
  - Only b′ has exp = 0: result is a.
- **Denormal inputs:** any input with exp = 0 is treated as zero.
- **Swap:** the operand with the larger |x| (compare bits [30:0]) becomes op1; its sign is the result sign.
- **Large exponent difference:** if diff = exp1 − exp2 > 26, the result is op1 unchanged.
- **Alignment:**
  - Mantissas are extended to 27 bits as {1, mant, 000}, giving guard, round and sticky bits.
  - op2 is shifted right by diff, and all shifted-out bits are ORed into bit 0.
- **Same signs (magnitude add):** 28-bit sum. If bit 27 is set, shift right by 1 keeping sticky, and exp + 1.
- **Different signs (magnitude subtract):**
  - A difference of 0 gives 0x00000000 (exact cancellation is always +0).
  - Otherwise normalise left using a leading-zero count (0–26).
  - If exp1 ≤ lzc, the result is signed... flushed to 0x00000000.
- **Rounding:** round to nearest even. Increment by 8 when bit2 && (bit3 | bit1 | bit0). If the mantissa carries out, shift right and exp + 1.
- **Final exponent:**
  - 0xff or above gives signed infinity {s, 0xff, 0}.
  - 0 gives signed zero {s, 31'b0}.
- **Tag:** carried through every stage unchanged.

## Timing
- **Stages:**
  - S1: unpack, classify, swap, align.
  - S2: add/subtract, leading-zero count, normalise.
  - S3: round, pack, special-case mux.
- **Latency:** a transfer at cycle t (`in_valid` && `in_ready`) produces `out_valid` at t+3 when there is no backpressure.
- **Throughput:** one operation per cycle.
- **Stall:**
  - adv = !out_valid || out_ready.
  - All stages and their valid bits advance only when adv = 1.
  - `in_ready` = adv.
- **Bubbles:** no compaction. An empty stage moves forward as a bubble.
- **Held output:** while `out_valid` && !`out_ready`, `c` and `out_tag` stay stable. Inputs offered during the stall are not accepted.
- **Special-case flags** are computed in S1 and piped to S3. They must not go through the rounding path.
- **Reset:**
  - On `rst_n` low, at any time and asynchronously, all stage valid bits clear: `out_valid` = 0, `c` = 0, `out_tag` = 0.
  - `in_ready` = 1 once reset is released.
  - Operations in flight at reset are discarded. Datapath registers other than the output register need no reset.

## Structure
- **Package `fpu_pkg`:**
  - Constants: `FP_QNAN` = 0x7fffffff, `FP_PINF` = 0x7f800000, `FP_NINF` = 0xff800000.
  - A special-case enum: NORMAL, NAN, INF, NINF, ZERO, RET_A, RET_B. Shared with the adder.
  - A `fp_unpacked_t` struct: sign, exp[7:0], mant[26:0].
- **Sub-module `fp_lzc27`:** combinational leading-zero count on 27 bits, returning 5 bits with 27 meaning all-zero. It is reused later by the adder rewrite.

## Test plan
- 0x40400000 − 0x3f800000 (3 − 1), `out_ready` = 1 → `c` = 0x40000000 exactly 3 cycles after acceptance, with the tag preserved.
- Cancellation and zeros:
  - 0x3f800000 − 0x3f800000 → 0x00000000.
  - 0x00000000 − 0x40000000 → 0xc0000000.
  - 0x40000000 − 0x00000001 (denormal) → 0x40000000.
- Infinities:
  - 0x7f800000 − 0x7f800000 → 0x7fffffff.
  - 0x7f800000 − 0xff800000 → 0x7f800000.
  - 0x7fc00000 − 0x3f800000 → 0x7fffffff.
- Overflow and large difference:
  - 0x7f7fffff − 0xff7fffff → 0x7f800000.
  - 0x5f800000 − 0x3f800000 (diff > 26) → 0x5f800000.
  - 0x3f800000 − 0x33800000 (1 − 2^−24, borrow and normalise) → 0x3f7fffff.
- Backpressure: 5 back-to-back operations with tags 0–4, `out_ready` held low for cycles 3–7 → `in_ready` falls, no operation is lost or duplicated, and results emerge in tag order 0–4.
- Reset: assert `rst_n` low mid-stream with 3 operations in flight → `out_valid` = 0 immediately. After release, the first new operation's result appears 3 cycles after acceptance and no stale results appear.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single constants, special-case codes
// and the unpacked operand layout used by the adder/subtractor datapaths.
package fpu_pkg;

  localparam logic [31:0] FP_QNAN = 32'h7fff_ffff;
  localparam logic [31:0] FP_PINF = 32'h7f80_0000;
  localparam logic [31:0] FP_NINF = 32'hff80_0000;

  typedef enum logic [2:0] {
    NORMAL,
    NAN,
    INF,
    NINF,
    ZERO,
    RET_A,
    RET_B
  } fp_special_e;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [26:0] mant;
  } fp_unpacked_t;

  // Hidden one, 23 fraction bits, then guard/round/sticky positions.
  function automatic fp_unpacked_t fp_unpack(input logic [31:0] x);
    fp_unpacked_t u;
    u.sign = x[31];
    u.exp  = x[30:23];
    u.mant = {1'b1, x[22:0], 3'b000};
    return u;
  endfunction

endpackage

// File: rtl/fsub_pipe_if.sv
// Issue-side and writeback-side handshake bundle of the pipelined subtractor.
interface fsub_pipe_if #(
  parameter int unsigned TAG_W = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      a;
  logic [31:0]      b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      c;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, a, b, in_tag, out_ready,
    input  in_ready, out_valid, c, out_tag
  );

  modport slave (
    input  in_valid, a, b, in_tag, out_ready,
    output in_ready, out_valid, c, out_tag
  );

endinterface

// File: rtl/fp_lzc27.sv
// Leading-zero count over 27 bits; an all-zero input returns 27.
module fp_lzc27 (
  input  logic [26:0] x,
  output logic [4:0]  cnt
);

  always_comb begin
    cnt = 5'd27;
    for (int unsigned i = 0; i < 27; i++) begin
      if (x[i]) cnt = 5'(26 - i);
    end
  end

endmodule

// File: rtl/fsub_pipe.sv
// Three-stage pipelined single-precision subtractor c = a - b with
// valid/ready handshakes; the whole pipe stalls on output backpressure.
module fsub_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input logic        clk,
  input logic        rst_n,
  fsub_pipe_if.slave bus
);

  logic adv;
  logic out_valid_q;
  logic [31:0] c_q;
  logic [TAG_W-1:0] out_tag_q;

  assign adv           = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.c         = c_q;
  assign bus.out_tag   = out_tag_q;

  // ---------------- S1: unpack, classify, swap, align ----------------
  logic [31:0]  bn, op1w, op2w, s1_bypass_d;
  fp_unpacked_t u1, u2;
  logic         swap;
  logic [7:0]   diff;
  logic [26:0]  lost_mask, m2_al;
  logic         a_max, b_max, a_nan, b_nan, a_inf, b_inf, a_den, b_den;
  fp_special_e  s1_sc_d;

  always_comb begin
    bn        = {~bus.b[31], bus.b[30:0]};
    swap      = bn[30:0] > bus.a[30:0];
    op1w      = swap ? bn : bus.a;
    op2w      = swap ? bus.a : bn;
    u1        = fp_unpack(op1w);
    u2        = fp_unpack(op2w);
    diff      = u1.exp - u2.exp;
    lost_mask = (27'd1 << diff) - 27'd1;
    m2_al     = (u2.mant >> diff) | {26'd0, |(u2.mant & lost_mask)};

    a_max = &bus.a[30:23];
    b_max = &bn[30:23];
    a_nan = a_max && (|bus.a[22:0]);
    b_nan = b_max && (|bn[22:0]);
    a_inf = a_max && !(|bus.a[22:0]);
    b_inf = b_max && !(|bn[22:0]);
    a_den = ~|bus.a[30:23];
    b_den = ~|bn[30:23];

    s1_sc_d = NORMAL;
    if (a_nan || b_nan)      s1_sc_d = NAN;
    else if (a_inf && b_inf) s1_sc_d = (bus.a[31] != bn[31]) ? NAN : (bus.a[31] ? NINF : INF);
    else if (a_inf)          s1_sc_d = bus.a[31] ? NINF : INF;
    else if (b_inf)          s1_sc_d = bn[31] ? NINF : INF;
    else if (a_den && b_den) s1_sc_d = ZERO;
    else if (a_den)          s1_sc_d = RET_B;
    else if (b_den)          s1_sc_d = RET_A;
    // A far-smaller op2 cannot move op1, so it rides the bypass path.
    else if (diff > 8'd26)   s1_sc_d = swap ? RET_B : RET_A;

    s1_bypass_d = (s1_sc_d == RET_B) ? bn : bus.a;
  end

  logic             s1_valid;
  logic [TAG_W-1:0] s1_tag;
  fp_special_e      s1_sc;
  logic [31:0]      s1_bypass;
  fp_unpacked_t     s1_op1;
  logic [26:0]      s1_m2;
  logic             s1_sub;

  // ---------------- S2: add/subtract, LZC, normalise ----------------
  logic [27:0] sum;
  logic [26:0] dif;
  logic [4:0]  lzc;
  fp_special_e s2_sc_d;
  logic [26:0] s2_m_d;
  logic [9:0]  s2_exp_d;

  fp_lzc27 u_lzc (
    .x   (dif),
    .cnt (lzc)
  );

  always_comb begin
    sum      = {1'b0, s1_op1.mant} + {1'b0, s1_m2};
    dif      = s1_op1.mant - s1_m2;
    s2_sc_d  = s1_sc;
    s2_m_d   = sum[26:0];
    s2_exp_d = {2'b00, s1_op1.exp};
    if (!s1_sub) begin
      if (sum[27]) begin
        s2_m_d   = {sum[27:2], sum[1] | sum[0]};
        s2_exp_d = {2'b00, s1_op1.exp} + 10'd1;
      end
    end else begin
      s2_m_d   = dif << lzc;
      s2_exp_d = {2'b00, s1_op1.exp} - {5'd0, lzc};
      // Exact cancellation and sub-normal results both become +0.
      if (s1_sc == NORMAL && (dif == '0 || s1_op1.exp <= {3'd0, lzc}))
        s2_sc_d = ZERO;
    end
  end

  logic             s2_valid;
  logic [TAG_W-1:0] s2_tag;
  fp_special_e      s2_sc;
  logic [31:0]      s2_bypass;
  logic             s2_sign;
  logic [26:0]      s2_m;
  logic [9:0]       s2_exp;

  // ---------------- S3: round, pack, special-case mux ----------------
  logic        inc;
  logic [24:0] rnd;
  logic [9:0]  exp_r;
  logic [22:0] mant_r;
  logic [31:0] norm_res, res;

  always_comb begin
    inc    = s2_m[2] & (s2_m[3] | s2_m[1] | s2_m[0]);
    rnd    = {1'b0, s2_m[26:3]} + {24'd0, inc};
    exp_r  = s2_exp + {9'd0, rnd[24]};
    mant_r = rnd[24] ? rnd[23:1] : rnd[22:0];

    if (exp_r >= 10'd255)    norm_res = {s2_sign, 8'hff, 23'd0};
    else if (exp_r == '0)    norm_res = {s2_sign, 31'd0};
    else                     norm_res = {s2_sign, exp_r[7:0], mant_r};

    unique case (s2_sc)
      NAN:          res = FP_QNAN;
      INF:          res = FP_PINF;
      NINF:         res = FP_NINF;
      ZERO:         res = '0;
      RET_A, RET_B: res = s2_bypass;
      default:      res = norm_res;
    endcase
  end

  // ---------------- Registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      out_tag_q   <= '0;
    end else if (adv) begin
      s1_valid    <= bus.in_valid;
      s2_valid    <= s1_valid;
      out_valid_q <= s2_valid;
      c_q         <= res;
      out_tag_q   <= s2_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_tag    <= bus.in_tag;
      s1_sc     <= s1_sc_d;
      s1_bypass <= s1_bypass_d;
      s1_op1    <= u1;
      s1_m2     <= m2_al;
      s1_sub    <= u1.sign ^ u2.sign;

      s2_tag    <= s1_tag;
      s2_sc     <= s2_sc_d;
      s2_bypass <= s1_bypass;
      s2_sign   <= s1_op1.sign;
      s2_m      <= s2_m_d;
      s2_exp    <= s2_exp_d;
    end
  end

endmodule
